eco32f_lsu: RTL

Load/store unit for the memory stage, directly downstream of the execute-stage ALU. It consumes the ALU's effective address and the store-data operand from execute, and runs one classic-Wishbone data-bus cycle per load/store. It stalls the pipeline until the bus acknowledges, then delivers a sign- or zero-extended load result to writeback. It also flags misaligned accesses and bus errors as memory-stage exceptions.

---
 rtl/eco32f_lsu_pkg.sv | 68 ++++++
 rtl/eco32f_lsu_align.sv | 15 +
 rtl/eco32f_lsu.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/eco32f_lsu_pkg.sv
// eco32f load/store unit: shared types and lane helpers (big-endian byte order).
package eco32f_lsu_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Byte-lane select; byte offset 0 is the most significant lane.
  function automatic logic [3:0] lsu_sel(lsu_size_e sz, logic [1:0] off);
    logic [3:0] s;
    case (sz)
      SZ_WORD: s = 4'b1111;
      SZ_HALF: s = off[1] ? 4'b0011 : 4'b1100;
      default: s = 4'b1000 >> off;
    endcase
    return s;
  endfunction

  // Store data replicated across every lane the size could land on.
  function automatic logic [31:0] lsu_wdata(lsu_size_e sz, logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_WORD: r = d;
      SZ_HALF: r = {d[15:0], d[15:0]};
      default: r = {4{d[7:0]}};
    endcase
    return r;
  endfunction

  function automatic logic lsu_misaligned(lsu_size_e sz, logic [1:0] off);
    logic m;
    case (sz)
      SZ_WORD: m = (off != 2'b00);
      SZ_HALF: m = off[0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Pick the addressed lane out of a bus word and sign/zero extend it.
  function automatic logic [31:0] lsu_ldext(lsu_size_e sz, logic sgn, logic [1:0] off,
                                            logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (sz)
      SZ_WORD: r = d;
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = {{24{sgn & b[7]}}, b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/eco32f_lsu_align.sv
// Lane select, store replication and alignment check for an incoming access.
module eco32f_lsu_align
  import eco32f_lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] data_o,
  output logic        misal_o
);
  assign sel_o   = lsu_sel(size_i, off_i);
  assign data_o  = lsu_wdata(size_i, data_i);
  assign misal_o = lsu_misaligned(size_i, off_i);
endmodule

// File: rtl/eco32f_lsu.sv
// eco32f memory-stage load/store unit driving a classic Wishbone data bus.
// Optional ECO32F_LSU_STORE_BUFFER_EN: one-entry posted store buffer with a
// sticky imprecise bus-error flag.
module eco32f_lsu
  import eco32f_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_stall,
  input  logic                  mem_stall,
  input  logic                  ex_flush,
  input  logic                  mem_flush,
  output logic                  lsu_stall,
  input  logic                  ex_op_ldw,
  input  logic                  ex_op_ldh,
  input  logic                  ex_op_ldhu,
  input  logic                  ex_op_ldb,
  input  logic                  ex_op_ldbu,
  input  logic                  ex_op_stw,
  input  logic                  ex_op_sth,
  input  logic                  ex_op_stb,
  input  logic [31:0]           ex_add_result,
  input  logic [31:0]           ex_rf_y,
  output logic                  mem_align_exc,
  output logic                  mem_bus_exc,
  output logic [31:0]           mem_bad_addr,
  output logic                  wb_op_load,
  output logic [31:0]           wb_lsu_result,
`ifdef ECO32F_LSU_STORE_BUFFER_EN
  output logic                  lsu_imprecise_err,
`endif
  output logic [ADDR_WIDTH-1:0] dbus_adr_o,
  output logic [31:0]           dbus_dat_o,
  output logic [3:0]            dbus_sel_o,
  output logic                  dbus_we_o,
  output logic                  dbus_cyc_o,
  output logic                  dbus_stb_o,
  input  logic [31:0]           dbus_dat_i,
  input  logic                  dbus_ack_i,
  input  logic                  dbus_err_i
);

  lsu_state_e  state_q, state_d;
  logic        pend_q, pend_d, launch_ex, launch_mem;
  logic        ex_ld, ex_st, ex_sgn, ex_misal, ex_go, enter;
  lsu_size_e   ex_size;
  logic [3:0]  ex_sel;
  logic [31:0] ex_wdat;

  logic        mem_ld_q, mem_st_q, mem_sgn_q, mem_misal_q;
  lsu_size_e   mem_size_q;
  logic [31:0] mem_addr_q, mem_wdat_q, hold_q, ld_ext;
  logic [3:0]  mem_sel_q;
  logic        done_q, err_q, kill_q, posted_q;
  logic        bus_end, own, ld_ready, bus_err_now;

  assign ex_ld  = ex_op_ldw | ex_op_ldh | ex_op_ldhu | ex_op_ldb | ex_op_ldbu;
  assign ex_st  = ex_op_stw | ex_op_sth | ex_op_stb;
  assign ex_sgn = ex_op_ldh | ex_op_ldb;

  // Size code from the one-hot decode.
  always_comb begin
    ex_size = SZ_BYTE;
    if (ex_op_ldh | ex_op_ldhu | ex_op_sth) ex_size = SZ_HALF;
    if (ex_op_ldw | ex_op_stw)              ex_size = SZ_WORD;
  end

  eco32f_lsu_align u_align (
    .size_i  (ex_size),
    .off_i   (ex_add_result[1:0]),
    .data_i  (ex_rf_y),
    .sel_o   (ex_sel),
    .data_o  (ex_wdat),
    .misal_o (ex_misal)
  );

  assign enter   = ~ex_stall;
  assign ex_go   = (ex_ld | ex_st) & ~ex_flush & ~ex_misal;
  assign bus_end = (state_q == S_ACCESS) & (dbus_ack_i | dbus_err_i);
  // A posted store's cycle no longer belongs to the op in the memory stage.
  assign own     = ~posted_q;
  assign ld_ext  = lsu_ldext(mem_size_q, mem_sgn_q, mem_addr_q[1:0], dbus_dat_i);

  // An op entering while the bus is still busy waits in pend_q and launches
  // from the memory-stage copy once the bus is idle.
  assign lsu_stall = pend_q | ((state_q == S_ACCESS) & ~(dbus_ack_i | dbus_err_i) & ~posted_q);

  // Next state, pending-launch bookkeeping and launch source select.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    launch_ex  = 1'b0;
    launch_mem = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q && !mem_flush) begin
          state_d    = S_ACCESS;
          launch_mem = 1'b1;
          pend_d     = 1'b0;
        end else if (!pend_q && enter && ex_go) begin
          state_d   = S_ACCESS;
          launch_ex = 1'b1;
        end
      end
      default: begin
        if (dbus_ack_i || dbus_err_i) state_d = S_IDLE;
        if (enter) pend_d = ex_go;
      end
    endcase
    if (mem_flush && pend_q && !launch_mem) pend_d = 1'b0;
  end

  // FSM state and pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Wishbone master outputs, registered on the launch edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_cyc_o <= 1'b0;
      dbus_stb_o <= 1'b0;
      dbus_we_o  <= 1'b0;
      dbus_adr_o <= '0;
      dbus_sel_o <= '0;
      dbus_dat_o <= '0;
    end else if (launch_ex) begin
      dbus_cyc_o <= 1'b1;
      dbus_stb_o <= 1'b1;
      dbus_we_o  <= ex_st;
      dbus_adr_o <= {ex_add_result[ADDR_WIDTH-1:2], 2'b00};
      dbus_sel_o <= ex_sel;
      dbus_dat_o <= ex_wdat;
    end else if (launch_mem) begin
      dbus_cyc_o <= 1'b1;
      dbus_stb_o <= 1'b1;
      dbus_we_o  <= mem_st_q;
      dbus_adr_o <= {mem_addr_q[ADDR_WIDTH-1:2], 2'b00};
      dbus_sel_o <= mem_sel_q;
      dbus_dat_o <= mem_wdat_q;
    end else if (bus_end) begin
      dbus_cyc_o <= 1'b0;
      dbus_stb_o <= 1'b0;
    end
  end

  // Execute-to-memory register plus per-op completion status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ld_q    <= 1'b0;
      mem_st_q    <= 1'b0;
      mem_sgn_q   <= 1'b0;
      mem_misal_q <= 1'b0;
      mem_size_q  <= SZ_BYTE;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdat_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      kill_q      <= 1'b0;
      hold_q      <= '0;
    end else if (enter) begin
      mem_ld_q    <= ex_ld & ~ex_flush;
      mem_st_q    <= ex_st & ~ex_flush;
      mem_sgn_q   <= ex_sgn;
      mem_misal_q <= ex_misal;
      mem_size_q  <= ex_size;
      mem_addr_q  <= ex_add_result;
      mem_sel_q   <= ex_sel;
      mem_wdat_q  <= ex_wdat;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      // Op moved on to writeback while execute holds: leave a bubble.
      if (!mem_stall) begin
        mem_ld_q <= 1'b0;
        mem_st_q <= 1'b0;
      end
      if (bus_end && own) begin
        done_q <= dbus_ack_i & ~dbus_err_i;
        err_q  <= dbus_err_i & ~kill_q & ~mem_flush;
        hold_q <= ld_ext;
      end
      if (mem_flush && state_q == S_ACCESS && own) kill_q <= 1'b1;
    end
  end

  assign ld_ready = mem_ld_q & ~kill_q &
                    ((bus_end & own & dbus_ack_i & ~dbus_err_i) | done_q);

  // Memory-to-writeback register for load results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_op_load    <= 1'b0;
      wb_lsu_result <= '0;
    end else if (!mem_stall) begin
      wb_op_load <= ld_ready & ~mem_flush;
      if (ld_ready) wb_lsu_result <= done_q ? hold_q : ld_ext;
    end
  end

  assign bus_err_now   = bus_end & own & dbus_err_i & ~kill_q & ~mem_flush & (mem_ld_q | mem_st_q);
  assign mem_align_exc = (mem_ld_q | mem_st_q) & mem_misal_q;
  assign mem_bus_exc   = bus_err_now | (err_q & (mem_ld_q | mem_st_q));
  assign mem_bad_addr  = (mem_align_exc | mem_bus_exc) ? mem_addr_q : 32'h0;

`ifdef ECO32F_LSU_STORE_BUFFER_EN
  logic imp_err_q;

  // Posted-store tracking and sticky error for writes nobody waits on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posted_q  <= 1'b0;
      imp_err_q <= 1'b0;
    end else begin
      if (launch_ex)       posted_q <= ex_st;
      else if (launch_mem) posted_q <= mem_st_q;
      else if (bus_end)    posted_q <= 1'b0;
      if (bus_end && posted_q && dbus_err_i) imp_err_q <= 1'b1;
    end
  end

  assign lsu_imprecise_err = imp_err_q;
`else
  assign posted_q = 1'b0;
`endif

endmodule
